// File: rtl/p17_usb_pkg.sv
// p17_usb_pkg: shared arbiter state encodings and round-robin select helper.
package p17_usb_pkg;
  typedef enum logic [1:0] {IDLE, ARB, XFER} arb_state_e;
  localparam int MAX_REQ = 8;
  // One-hot of the first set bit of valid at or after ptr, wrapping modulo n.
  function automatic logic [MAX_REQ-1:0] rr_select(input logic [MAX_REQ-1:0] valid, input logic [2:0] ptr, input int n);
    logic [MAX_REQ-1:0] sel;
    int idx;
    sel = '0;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % n;
      if (i < n && valid[idx]) sel = MAX_REQ'(1) << idx;
    end
    return sel;
  endfunction
endpackage

// File: rtl/p17_rr_pick.sv
// p17_rr_pick: combinational round-robin one-hot select from a valid vector and pointer.
module p17_rr_pick
  import p17_usb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] valid_i,
  input  logic [2:0]   ptr_i,
  output logic [N-1:0] pick_o
);
  assign pick_o = N'(rr_select(MAX_REQ'(valid_i), ptr_i, N));
endmodule

// File: rtl/p17_in_arb.sv
// p17_in_arb: round-robin arbiter merging requester byte streams into one in-stream,
// with per-grant burst cap and idle timeout.
module p17_in_arb
  import p17_usb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int MAX_BURST    = 8,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [7:0]           in_data_o,
  output logic                 in_valid_o,
  input  logic                 in_ready_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 busy_o
);
  arb_state_e state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d, pick;
  logic [2:0] rr_ptr_q, rr_ptr_d, g;
  logic [6:0] byte_cnt_q, byte_cnt_d, cnt_inc;
  logic [7:0] idle_cnt_q, idle_cnt_d, idle_nx;
  logic [7:0] data_g;
  logic valid_g, last_g, xfer_st, fire, done;

  p17_rr_pick #(.N(NUM_REQ)) u_pick (
    .valid_i(req_valid_i),
    .ptr_i  (rr_ptr_q),
    .pick_o (pick)
  );

  always_comb begin
    g = '0;
    valid_g = 1'b0;
    last_g = 1'b0;
    data_g = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_q[k]) begin
        g = 3'(k);
        valid_g = req_valid_i[k];
        last_g = req_last_i[k];
        data_g = req_data_i[8*k +: 8];
      end
    end
  end

  assign xfer_st     = state_q == XFER;
  assign in_valid_o  = xfer_st & valid_g;
  assign in_data_o   = xfer_st ? data_g : '0;
  assign req_ready_o = (xfer_st & in_ready_i) ? grant_q : '0;
  assign fire        = in_valid_o & in_ready_i;
  assign cnt_inc     = byte_cnt_q + 7'd1;
  // Backpressured cycles keep valid high, so they clear rather than advance the idle count.
  assign idle_nx     = valid_g ? 8'd0 : (idle_cnt_q == 8'(IDLE_TIMEOUT) ? idle_cnt_q : idle_cnt_q + 8'd1);
  assign done        = (fire & (last_g | cnt_inc == 7'(MAX_BURST))) | idle_nx == 8'(IDLE_TIMEOUT);
  assign grant_o     = grant_q;
  assign busy_o      = xfer_st;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_ptr_d = rr_ptr_q;
    byte_cnt_d = byte_cnt_q;
    idle_cnt_d = idle_cnt_q;
    case (state_q)
      IDLE: state_d = |req_valid_i ? ARB : IDLE;
      ARB: begin
        state_d = |pick ? XFER : IDLE;
        grant_d = pick;
        byte_cnt_d = '0;
        idle_cnt_d = '0;
      end
      XFER: begin
        byte_cnt_d = fire ? cnt_inc : byte_cnt_q;
        idle_cnt_d = idle_nx;
        if (done) begin
          state_d = IDLE;
          grant_d = '0;
          rr_ptr_d = g == 3'(NUM_REQ - 1) ? 3'd0 : g + 3'd1;
          byte_cnt_d = '0;
          idle_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_ptr_q <= '0;
      byte_cnt_q <= '0;
      idle_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      byte_cnt_q <= byte_cnt_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end
endmodule

// File: tb/tb_p17_in_arb.sv
// tb_p17_in_arb: directed-vector bench for p17_in_arb with queue-driven requesters.
module tb_p17_in_arb;
  localparam int N = 4;
  logic clk_i = 1'b0;
  logic rstn_i = 1'b0;
  logic [N-1:0] req_valid_i, req_last_i, req_ready_o, grant_o;
  logic [8*N-1:0] req_data_i;
  logic [7:0] in_data_o;
  logic in_valid_o, in_ready_i, busy_o;

  always #5 clk_i = ~clk_i;

  p17_in_arb #(.NUM_REQ(N), .MAX_BURST(8), .IDLE_TIMEOUT(16)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_last_i(req_last_i),
    .req_ready_o(req_ready_o), .in_data_o(in_data_o), .in_valid_o(in_valid_o),
    .in_ready_i(in_ready_i), .grant_o(grant_o), .busy_o(busy_o)
  );

  logic [8:0] q [N][$];
  int n_chk = 0, n_fail = 0;
  int cyc, last_end, n_xf, bp_after, bp_left;
  logic busy_prev;
  int gr_req[$], gr_cnt[$], gr_len[$], gaps[$], xf_cyc[$];
  logic [N-1:0] gr_vec[$];
  logic [7:0] xf_data[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    logic [8:0] h;
    for (int k = 0; k < N; k++) begin
      h = q[k].size() > 0 ? q[k][0] : 9'h0;
      req_valid_i[k] = q[k].size() > 0;
      req_last_i[k] = h[8];
      req_data_i[8*k +: 8] = h[7:0];
    end
    in_ready_i = !(bp_left > 0 && n_xf == bp_after);
  endtask

  function automatic bit all_empty();
    for (int k = 0; k < N; k++) if (q[k].size() > 0) return 0;
    return 1;
  endfunction

  task automatic clear_log();
    gr_req.delete(); gr_cnt.delete(); gr_len.delete(); gaps.delete();
    xf_cyc.delete(); gr_vec.delete(); xf_data.delete();
    cyc = 0; last_end = -1; n_xf = 0; bp_after = -1; bp_left = 0; busy_prev = 1'b0;
  endtask

  task automatic step();
    logic [N-1:0] pop;
    logic [8:0] h;
    bit fire;
    pop = '0;
    drive();
    #1;
    if (busy_o && !busy_prev) begin
      if (last_end >= 0) gaps.push_back(cyc - last_end - 1);
      gr_req.push_back(-1);
      for (int k = 0; k < N; k++) if (grant_o[k]) gr_req[gr_req.size()-1] = k;
      gr_vec.push_back(grant_o);
      gr_cnt.push_back(0);
      gr_len.push_back(0);
    end
    if (busy_o) begin
      gr_len[gr_len.size()-1]++;
      last_end = cyc;
    end
    for (int k = 0; k < N; k++) pop[k] = req_valid_i[k] && req_ready_o[k];
    fire = in_valid_o && in_ready_i;
    check("pop_vs_fire", $countones(pop), 32'(fire));
    for (int k = 0; k < N; k++) begin
      if (pop[k] && fire) begin
        h = q[k][0];
        check("xfer_data", in_data_o, h[7:0]);
        xf_data.push_back(in_data_o);
        xf_cyc.push_back(cyc);
        n_xf++;
        if (gr_cnt.size() > 0) gr_cnt[gr_cnt.size()-1]++;
      end
    end
    if (!in_ready_i) bp_left--;
    busy_prev = busy_o;
    @(posedge clk_i);
    #1;
    cyc++;
    for (int k = 0; k < N; k++) if (pop[k]) void'(q[k].pop_front());
  endtask

  task automatic run(input int max);
    int i;
    for (i = 0; i < max; i++) begin
      step();
      if (all_empty() && !busy_o) break;
    end
    check("run_bound", 32'(i < max), 32'd1);
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    for (int k = 0; k < N; k++) q[k].delete();
    clear_log();
    drive();
    repeat (2) @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
  endtask

  task automatic push_msg(input int k, input int base, input int len, input bit with_last);
    for (int i = 0; i < len; i++) q[k].push_back({with_last && i == len - 1, 8'(base + i)});
  endtask

  task automatic check_idle_outs(input string tag);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_grant"}, grant_o, 0);
    check({tag, "_in_valid"}, in_valid_o, 0);
    check({tag, "_req_ready"}, req_ready_o, 0);
    check({tag, "_in_data"}, in_data_o, 0);
  endtask

  initial begin
    do_reset();
    check_idle_outs("reset");

    // Single requester, three bytes, last on the third.
    push_msg(1, 'hA1, 3, 1);
    run(40);
    check("single_ngrants", gr_req.size(), 1);
    check("single_grant_vec", gr_vec[0], 4'b0010);
    check("single_nbytes", gr_cnt[0], 3);
    check("single_latency", xf_cyc[0], 2);
    for (int i = 0; i < 3; i++) check("single_data", xf_data[i], 'hA1 + i);
    check("single_busy_len", gr_len[0], 3);
    check_idle_outs("single_after");

    // Burst cap 8, trailing 4-byte grant ends by 16-cycle timeout.
    do_reset();
    push_msg(0, 'h10, 20, 0);
    run(200);
    check("burst_ngrants", gr_req.size(), 3);
    check("burst_cnt0", gr_cnt[0], 8);
    check("burst_cnt1", gr_cnt[1], 8);
    check("burst_cnt2", gr_cnt[2], 4);
    check("burst_len0", gr_len[0], 8);
    check("burst_len2", gr_len[2], 20);
    check("burst_gap0", gaps[0], 2);
    check("burst_gap1", gaps[1], 2);
    for (int i = 0; i < 20; i++) check("burst_data", xf_data[i], 'h10 + i);

    // Fairness across requesters 0, 2, 3 with two 8-byte messages each.
    do_reset();
    for (int m = 0; m < 2; m++) begin
      push_msg(0, 'h00 + 8*m, 8, 1);
      push_msg(2, 'h80 + 8*m, 8, 1);
      push_msg(3, 'hC0 + 8*m, 8, 1);
    end
    run(300);
    check("fair_ngrants", gr_req.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check("fair_order", gr_req[i], i % 3 == 0 ? 0 : (i % 3 == 1 ? 2 : 3));
      check("fair_cnt", gr_cnt[i], 8);
    end
    for (int i = 0; i < 5; i++) check("fair_gap", gaps[i], 2);

    // Backpressure for 40 cycles after the third byte.
    do_reset();
    push_msg(1, 'h80, 8, 1);
    bp_after = 3;
    bp_left = 40;
    run(200);
    check("bp_ngrants", gr_req.size(), 1);
    check("bp_cnt", gr_cnt[0], 8);
    check("bp_len", gr_len[0], 48);
    check("bp_done", bp_left, 0);
    for (int i = 0; i < 8; i++) check("bp_data", xf_data[i], 'h80 + i);

    // Reset mid-transfer: pointer is 2 before reset, must restart from 0.
    do_reset();
    push_msg(1, 'h55, 1, 1);
    run(40);
    push_msg(2, 'h20, 8, 1);
    push_msg(0, 'h30, 4, 1);
    push_msg(3, 'h40, 2, 1);
    for (int i = 0; i < 60 && n_xf < 4; i++) step();
    check("rst_pre_nxf", n_xf, 4);
    check("rst_pre_grant", gr_req[1], 2);
    rstn_i = 1'b0;
    #1;
    check_idle_outs("rst_mid");
    q[2].delete();
    @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    clear_log();
    run(100);
    check("rst_ngrants", gr_req.size(), 2);
    check("rst_first", gr_req[0], 0);
    check("rst_second", gr_req[1], 3);
    check("rst_cnt0", gr_cnt[0], 4);
    check("rst_cnt1", gr_cnt[1], 2);
    check("rst_data0", xf_data[0], 'h30);

    // Last coincides with burst cap; requester 1 pending.
    do_reset();
    push_msg(0, 'h60, 8, 1);
    push_msg(1, 'h70, 2, 1);
    run(100);
    check("coin_ngrants", gr_req.size(), 2);
    check("coin_first", gr_req[0], 0);
    check("coin_second", gr_req[1], 1);
    check("coin_cnt0", gr_cnt[0], 8);
    check("coin_cnt1", gr_cnt[1], 2);
    check("coin_gap", gaps[0], 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
